sram_read_streamer: RTL
=======================

# sram_read_streamer

Read-side DMA stage that sits directly downstream of the averaging block's `sram` buffer. On a `START` command it issues sequential word reads to the SRAM read port and forwards the returned words as a valid/ready stream, tagging the final word with `OUT_LAST`. It owns the SRAM's registered one-cycle read latency and absorbs downstream backpressure, so the consumer never sees dropped or duplicated words.

## Interface
Parameters:
- `address_width`, default 16: byte-address width. Must match the SRAM instance.
- `data_width`, default 6: log2 of the word size in bytes. Must match the SRAM instance.
- Derived `AW = address_width - data_width`: word-address width (10 at defaults).
- Derived `DW = (1<<data_width)*8`: word width in bits (512 at defaults).

Ports:
- `CLK`, in, 1: the single clock; all logic is rising-edge.
- `RST`, in, 1: reset, synchronous and active-high.
- `START`, in, 1: begin a transfer. Sampled only while idle.
- `BASE_ADDR`, in, AW: first word address. Captured when `START` is accepted.
- `COUNT`, in, AW+1: number of words to transfer, range 0..2^AW. Captured when `START` is accepted.
- `BUSY`, out, 1: a transfer is in progress.
- `DONE`, out, 1: one-cycle pulse when a transfer completes.
- `MEM_READ_ADDR`, out, AW: drives the SRAM `READ_ADDR`.
- `MEM_OE`, out, 1: drives the SRAM `OE`.
- `MEM_DATA_IN`, in, DW: from the SRAM `DATA_OUT`. Valid in the cycle after `MEM_OE`=1.
- `OUT_DATA`, out, DW: stream data.
- `OUT_VALID`, out, 1: stream valid.
- `OUT_READY`, in, 1: stream ready from the consumer.
- `OUT_LAST`, out, 1: marks the final word of the transfer. Qualified by `OUT_VALID`.

## Operation
- States:
  - IDLE: waiting for a command.
  - READ: issuing SRAM reads.
  - FLUSH: all reads issued; draining the buffer.
  - FIN: transfer complete.
- IDLE → READ when `START`=1 and `COUNT`≠0. The block latches the base address and count, and clears the issued and sent counters.
- IDLE → FIN when `START`=1 and `COUNT`=0. No read is issued and no beat is output.
- READ → FLUSH in the cycle in which the last read is issued.
- FLUSH → FIN on the handshake of the final beat (`OUT_VALID` & `OUT_READY` & `OUT_LAST`).
- FIN → IDLE unconditionally after one cycle.
- `START` is ignored in READ, FLUSH and FIN.
- Read issue rule: in READ, `MEM_OE`=1 whenever (buffer occupancy + in-flight reads) < 3.
  - The rule does not credit a pop happening in the same cycle.
  - At most one read is in flight at a time.
  - `MEM_READ_ADDR` = base + issued count, modulo 2^AW, so the address wraps from 2^AW−1 to 0.
  - Outside READ, `MEM_OE`=0 and `MEM_READ_ADDR` holds its last value.
- Return path: `MEM_DATA_IN` is written into a 3-entry FIFO only in the cycle immediately after a `MEM_OE`=1 cycle. It is never sampled otherwise, because the SRAM holds stale data when OE is low.
- FIFO output drives `OUT_DATA` and `OUT_VALID`. `OUT_VALID` = FIFO not empty.
- `OUT_DATA` and `OUT_LAST` stay stable while `OUT_VALID`=1 and `OUT_READY`=0.
- `OUT_LAST` = 1 when (sent count = `COUNT` − 1) and `OUT_VALID`=1.
- Counters are AW+1 bits wide so that `COUNT` = 2^AW is handled.
- The FIFO never overflows; the issue rule guarantees this. A simultaneous push and pop on the FIFO is legal at any occupancy.
- `BUSY` = 1 in READ and FLUSH. `DONE` = 1 in FIN only.
- Reset, including mid-transfer:
  - Next state is IDLE and the FIFO and counters are cleared.
  - `BUSY`=0, `DONE`=0, `MEM_OE`=0, `MEM_READ_ADDR`=0, `OUT_VALID`=0, `OUT_LAST`=0, `OUT_DATA`=0.
  - A read that was in flight at reset is discarded.

## Timing
- Cycle 0 is the `START` cycle, in IDLE.
- First `MEM_OE` with `MEM_READ_ADDR`=`BASE_ADDR` is in cycle 1. `BUSY` rises in cycle 1.
- The first word is captured at the end of cycle 2. `OUT_VALID` is first asserted in cycle 3.
- Latency from `START` to the first beat is 3 cycles.
- With `OUT_READY` held at 1, throughput is 1 word per cycle: N words occupy cycles 3..N+2, and `DONE` pulses in cycle N+3.
- `DONE` and `BUSY`=0 coincide in FIN. A new `START` is accepted in the IDLE cycle that follows FIN.
- With `COUNT`=0: `DONE` pulses in cycle 1 and `BUSY` stays 0.

## Test plan
- Basic transfer: `BASE_ADDR`=0x010, `COUNT`=4, `OUT_READY`=1.
  - `MEM_OE` in cycles 1–4 with addresses 0x010–0x013.
  - Beats in cycles 3–6 with data in address order; `OUT_LAST` in cycle 6.
  - `DONE` in cycle 7.
- Backpressure: `COUNT`=16, `OUT_READY` driven by a random pattern with 50% duty.
  - All 16 words arrive exactly once, in order.
  - `OUT_DATA` is stable while stalled.
  - `MEM_OE`=0 whenever occupancy + in-flight = 3.
- Wrap-around: `BASE_ADDR`=0x3FE, `COUNT`=3 at default parameters → addresses 0x3FE, 0x3FF, 0x000.
- `COUNT`=0 → `DONE` in cycle 1; no `MEM_OE`, no `OUT_VALID`, `BUSY` never asserted.
- `START` pulsed again while `BUSY`, and `BASE_ADDR` changed mid-transfer → neither affects the running transfer; exactly `COUNT` beats are output.
- `RST` asserted for 1 cycle after the 2nd beat of an 8-word transfer, with `OUT_READY`=0 → the next cycle is idle with all outputs at their reset values. A following `START` with `COUNT`=2 delivers exactly 2 fresh beats.

Source files
------------

// File: rtl/sram_read_streamer.sv
// Read-side DMA streamer: issues sequential SRAM word reads on START and
// forwards the returned words as a valid/ready stream, marking the last word.
module sram_read_streamer #(
  parameter int  address_width = 16,
  parameter int  data_width    = 6,
  localparam int AW            = address_width - data_width,
  localparam int DW            = (1 << data_width) * 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] BASE_ADDR,
  input  logic [AW:0]   COUNT,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] MEM_READ_ADDR,
  output logic          MEM_OE,
  input  logic [DW-1:0] MEM_DATA_IN,
  output logic [DW-1:0] OUT_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic          OUT_LAST
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [AW-1:0] r_base;
  logic [AW-1:0] r_addr_hold;
  logic [AW:0]   r_count;
  logic [AW:0]   r_issued;
  logic [AW:0]   r_sent;
  logic          r_inflight;
  logic [DW-1:0] r_fifo [3];
  logic [1:0]    r_wptr;
  logic [1:0]    r_rptr;
  logic [1:0]    r_occ;

  logic          w_oe;
  logic          w_push;
  logic          w_pop;
  logic          w_last_issue;
  logic [AW-1:0] w_addr;
  logic [AW:0]   w_count_m1;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reads are throttled so buffered words plus the one in flight never exceed
  // the three FIFO slots; a same-cycle pop is deliberately not credited.
  assign w_oe         = (r_state == S_READ) &&
                        (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd3);
  assign w_addr       = r_base + r_issued[AW-1:0];
  assign w_count_m1   = r_count - ONE;
  assign w_last_issue = w_oe && (r_issued == w_count_m1);
  assign w_push       = r_inflight;
  assign w_pop        = OUT_VALID && OUT_READY;

  assign MEM_OE        = w_oe;
  assign MEM_READ_ADDR = (r_state == S_READ) ? w_addr : r_addr_hold;
  assign BUSY          = (r_state == S_READ) || (r_state == S_FLUSH);
  assign DONE          = (r_state == S_FIN);
  assign OUT_VALID     = (r_occ != 2'd0);
  assign OUT_DATA      = OUT_VALID ? r_fifo[r_rptr] : '0;
  assign OUT_LAST      = OUT_VALID && (r_sent == w_count_m1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_addr_hold <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_sent      <= '0;
      r_inflight  <= 1'b0;
      r_wptr      <= 2'd0;
      r_rptr      <= 2'd0;
      r_occ       <= 2'd0;
    end else begin
      r_inflight <= w_oe;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_base   <= BASE_ADDR;
            r_count  <= COUNT;
            r_issued <= '0;
            r_sent   <= '0;
            r_state  <= (COUNT == '0) ? S_FIN : S_READ;
          end
        end
        S_READ: begin
          if (w_oe) begin
            r_issued    <= r_issued + ONE;
            r_addr_hold <= w_addr;
          end
          if (w_last_issue) r_state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (w_pop && OUT_LAST) r_state <= S_FIN;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_pop) begin
        r_sent <= r_sent + ONE;
        r_rptr <= next_ptr(r_rptr);
      end
      if (w_push) r_wptr <= next_ptr(r_wptr);
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // NOTE: the FIFO storage is not reset; pointers and occupancy are, and
  // OUT_DATA is gated by OUT_VALID, so stale contents are never observable.
  always_ff @(posedge CLK) begin
    if (w_push) r_fifo[r_wptr] <= MEM_DATA_IN;
  end

endmodule
